// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Used by imem_fetch_ctrl and fetch_skid_buf.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        HALT,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] INSTR_HALT = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched {pc, instr} pairs for decode.
// Flush has priority over push and pop.
module fetch_skid_buf
    import imem_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         rd_q;
    logic         wr;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);
    // Tail slot: rd for count 0/2, the other slot for count 1.
    assign wr     = rd_q ^ count[0];
    assign head   = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count <= 2'd0;
            rd_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr] <= din;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count <= count + 2'(push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, captures words into a 2-entry buffer.
// Optional FETCH_PERF_CNT_EN adds fetch/stall/flush counters.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic        fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t din;
    logic         redir;
    logic         pop;
    logic         space;
    logic         fetch;
    logic         bad_pc;
    logic         push;

    assign redir  = redirect_valid && (state_q != INIT);
    assign pop    = if_valid && if_ready;
    assign space  = (count != 2'd2) || pop;
    assign fetch  = (state_q == RUN) && !redir && space;
    // 33-bit sum so a PC near 2^32 cannot wrap past the range check.
    assign bad_pc = (pc_q[1:0] != 2'b00)
                 || (({1'b0, pc_q} + 33'd3) >= 33'(MEM_BYTES));
    assign din    = '{pc: pc_q, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (redir) begin
            state_d = RUN;
            pc_d    = redirect_pc;
        end else if (state_q == INIT) begin
            state_d = RUN;
        end else if (fetch) begin
            if (bad_pc) begin
                state_d = FAULT;
            end else if (imem_rdata == INSTR_HALT) begin
                state_d = HALT;
            end else begin
                push = 1'b1;
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    fetch_skid_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (din),
        .count (count),
        .head  (head)
    );

    assign imem_addr = pc_q;
    assign if_valid  = (count != 2'd0);
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;
    assign halted    = (state_q == HALT);
    assign fault     = (state_q == FAULT);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 16'd0;
        end else begin
            if (push && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state_q == RUN) && (count == 2'd2) && !pop
                && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redir && (count != 2'd0) && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed plan steps
// followed by random-program runs checked against a delivery model.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;
    logic        fault;

    logic [31:0] mem [8];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (imem_addr < 32'd32) imem_rdata = mem[imem_addr[4:2]];
        else                    imem_rdata = 32'hDEAD_BEEF;
    end

    imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_BYTES(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .halted         (halted),
        .fault          (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_prog();
        mem[0] = 32'hFFC4A303; mem[1] = 32'h413903B3;
        mem[2] = 32'h00940333; mem[3] = 32'h00000000;
        mem[4] = 32'h11111111; mem[5] = 32'h22222222;
        mem[6] = 32'h33333333; mem[7] = 32'h00A00093;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        cyc(3);
        reset = 1'b1;
    endtask

    // Random-program run: words 0..k-1 nonzero, word k zero (k==8: no
    // zero, so the sequence ends with a range fault at PC 32).
    task automatic rand_run(input int iter);
        int k, idx, n;
        bit held, done;
        logic [31:0] hpc, hins, exp_instr;
        k = $urandom_range(1, 8);
        for (int i = 0; i < 8; i++) mem[i] = $urandom() | 32'h1;
        if (k < 8) mem[k] = 32'h0;
        if_ready = 1'b0;
        do_reset();
        idx = 0; held = 0; done = 0; n = 0;
        hpc = '0; hins = '0;
        while (!done && n < 300) begin
            cyc(1);
            n++;
            if (held && if_valid) begin
                chk($sformatf("r%0d_stable_pc", iter), if_pc, hpc);
                chk($sformatf("r%0d_stable_in", iter), if_instr, hins);
            end
            if ((halted || fault) && !if_valid) begin
                done = 1;
            end else begin
                if_ready = 1'($urandom_range(0, 1));
                if (if_valid && if_ready) begin
                    exp_instr = (idx < k) ? mem[idx] : 32'hXXXXXXXX;
                    chk($sformatf("r%0d_pc%0d", iter, idx),
                        if_pc, 32'(idx * 4));
                    chk($sformatf("r%0d_in%0d", iter, idx),
                        if_instr, exp_instr);
                    idx++;
                end
                held = if_valid && !if_ready;
                hpc = if_pc;
                hins = if_instr;
            end
        end
        chk($sformatf("r%0d_done", iter), 32'(done), 32'd1);
        chk($sformatf("r%0d_count", iter), 32'(idx), 32'(k));
        chk($sformatf("r%0d_halted", iter), 32'(halted), 32'(k < 8));
        chk($sformatf("r%0d_fault", iter), 32'(fault), 32'(k == 8));
    endtask

    initial begin
        int n;
        load_prog();

        // Reset and free-running fetch up to the halt word.
        if_ready = 1'b1;
        do_reset();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        cyc(1);
        chk("init_valid", 32'(if_valid), 32'd0);
        cyc(1);
        chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'hFFC4A303);
        cyc(1);
        chk("seq_pc4", if_pc, 32'h4);
        chk("seq_in4", if_instr, 32'h413903B3);
        cyc(1);
        chk("seq_pc8", if_pc, 32'h8);
        chk("seq_in8", if_instr, 32'h00940333);
        cyc(1);
        chk("halt_valid", 32'(if_valid), 32'd0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_addr", imem_addr, 32'hC);
        chk("halt_nofault", 32'(fault), 32'd0);

        // Backpressure with a full buffer.
        if_ready = 1'b0;
        do_reset();
        cyc(2);
        chk("bp_first", if_pc, 32'h0);
        cyc(5);
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_head_pc", if_pc, 32'h0);
        chk("bp_head_in", if_instr, 32'hFFC4A303);
        chk("bp_valid", 32'(if_valid), 32'd1);
        if_ready = 1'b1;
        chk("bp_rel0", if_pc, 32'h0);
        cyc(1);
        chk("bp_rel4", if_pc, 32'h4);
        cyc(1);
        chk("bp_rel8", if_pc, 32'h8);
        chk("bp_rel8v", 32'(if_valid), 32'd1);
        cyc(1);
        chk("bp_end_valid", 32'(if_valid), 32'd0);
        chk("bp_end_halt", 32'(halted), 32'd1);

        // Redirect flushes a full buffer.
        if_ready = 1'b0;
        do_reset();
        cyc(4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h4;
        cyc(1);
        redirect_valid = 1'b0;
        chk("rd_flush_valid", 32'(if_valid), 32'd0);
        chk("rd_addr", imem_addr, 32'h4);
        cyc(1);
        chk("rd_pc", if_pc, 32'h4);
        chk("rd_instr", if_instr, 32'h413903B3);
        chk("rd_valid", 32'(if_valid), 32'd1);
        chk("rd_nohalt", 32'(halted), 32'd0);
        if_ready = 1'b1;
        n = 0;
        while (!halted && n < 20) begin cyc(1); n++; end
        chk("rd_reach_halt", 32'(halted), 32'd1);

        // Redirect out of HALT.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        cyc(1);
        redirect_valid = 1'b0;
        chk("unhalt_flag", 32'(halted), 32'd0);
        chk("unhalt_addr", imem_addr, 32'h0);
        cyc(1);
        chk("unhalt_valid", 32'(if_valid), 32'd1);
        chk("unhalt_pc", if_pc, 32'h0);

        // Misaligned redirect, then range overrun.
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        cyc(1);
        redirect_valid = 1'b0;
        chk("mis_nofault_yet", 32'(fault), 32'd0);
        cyc(1);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_valid", 32'(if_valid), 32'd0);
        chk("mis_nohalt", 32'(halted), 32'd0);
        cyc(2);
        chk("mis_hold", 32'(fault), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd28;
        cyc(1);
        redirect_valid = 1'b0;
        chk("top_clear", 32'(fault), 32'd0);
        cyc(1);
        chk("top_pc", if_pc, 32'd28);
        chk("top_instr", if_instr, 32'h00A00093);
        cyc(1);
        chk("oor_fault", 32'(fault), 32'd1);
        chk("oor_valid", 32'(if_valid), 32'd0);

        // Reset mid-stream with two buffered entries.
        if_ready = 1'b0;
        do_reset();
        cyc(4);
        chk("mid_pre_addr", imem_addr, 32'h8);
        reset = 1'b0;
        cyc(1);
        chk("mid_valid", 32'(if_valid), 32'd0);
        chk("mid_addr", imem_addr, 32'h0);
        chk("mid_halted", 32'(halted), 32'd0);
        chk("mid_fault", 32'(fault), 32'd0);

        for (int it = 0; it < 6; it++) rand_run(it);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the byte-addressed, combinational-read instruction memory.
- Owns the PC and drives the memory address.
- Captures returned 32-bit words into a 2-entry buffer.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles branch/jump redirects, halts on an all-zero word, and faults on misaligned or out-of-range fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_BYTES, 32, instruction memory size in bytes; valid fetch requires PC+3 < MEM_BYTES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge
- imem_addr  out  32  byte address to instruction memory (= PC register)
- imem_rdata  in  32  little-endian word returned combinationally for imem_addr
- redirect_valid  in  1  redirect request from execute
- redirect_pc  in  32  redirect target
- if_valid  out  1  buffer head valid to decode
- if_ready  in  1  decode accepts head when if_valid&if_ready
- if_pc  out  32  PC of head instruction
- if_instr  out  32  head instruction word
- halted  out  1  fetch stopped on zero word
- fault  out  1  fetch stopped on misaligned or out-of-range PC

Behaviour:
- States: INIT, RUN, HALT, FAULT.
- Reset (reset==0 at edge):
  - PC<=RESET_PC; buffer emptied; state<=INIT.
  - Outputs: if_valid=0, halted=0, fault=0, imem_addr=RESET_PC.
  - Reset mid-operation discards all buffered entries.
- INIT: one idle cycle after reset release so memory contents settle; no capture. Then ->RUN.
- RUN, fetch fires when buffer has space (count<2, or count==2 with pop this cycle) and there is no redirect:
  - If PC[1:0]!=0 or PC+3 >= MEM_BYTES: ->FAULT, no enqueue.
  - Else if imem_rdata==0: ->HALT, no enqueue, PC unchanged.
  - Else: enqueue {PC, imem_rdata}; PC<=PC+4 (32-bit, no wrap handling; range check catches overrun).
- Pop: if_valid&if_ready removes the head. Push and pop in the same cycle are allowed at any count. Order is strictly FIFO.
- Latency: a word captured at edge N is visible on if_valid after edge N (registered buffer). Steady-state throughput is 1 instruction/cycle with if_ready held high.
- Backpressure: with count==2 and if_ready=0, no fetch occurs and PC holds. if_pc/if_instr are stable while if_valid=1 and not accepted.
- Redirect (any state except INIT):
  - Highest priority.
  - Flush the buffer (a same-cycle pop is ignored) and set PC<=redirect_pc.
  - Clear halted/fault; state<=RUN.
  - No capture that cycle. First redirected word is presented the cycle after the following edge.
  - A misaligned redirect_pc faults on the next RUN cycle.
- HALT/FAULT:
  - No further fetches; halted or fault held at 1.
  - Buffered entries still drain to decode.
  - Only reset or redirect exits.
- halted and fault are never 1 simultaneously.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] (words enqueued), perf_stall_cnt[31:0] (RUN cycles with buffer full and no pop) and perf_flush_cnt[15:0] (redirects that discarded ≥1 valid entry).
  - All three reset to 0, saturate at max and do not wrap.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package imem_fetch_pkg:
  - fetch_state_t enum {INIT, RUN, HALT, FAULT}
  - PC_STEP=4, INSTR_HALT=32'h0
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
- Sub-module fetch_skid_buf: 2-entry FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push/pop.

Test Plan:
- Reset low 3 cycles, then high, if_ready=1, memory holds FFC4A303/413903B3/00940333/00000000 at 0/4/8/12 -> if_valid first high 2 cycles after release with pc 0/instr FFC4A303; then pc 4 (413903B3) and pc 8 (00940333) on consecutive cycles; halted=1 when PC=12; if_valid drops after pc 8.
- Same program, if_ready=0 for 5 cycles after first valid -> buffer holds pc 0 and 4, imem_addr frozen at 8, head stable; release -> pc 0, 4, 8 delivered back-to-back, no loss or duplication.
- redirect_valid with redirect_pc=4 while buffer holds 2 entries -> both flushed, next delivered pc=4 instr 413903B3; halted stays 0.
- After halt at 12, redirect_pc=0 -> halted clears, fetch restarts at pc 0.
- redirect_pc=6 -> fault=1 next cycle, no new if_valid. redirect_pc=28 with nonzero word at 28 -> delivered, then PC=32 → fault=1.
- Assert reset low mid-stream with 2 buffered entries -> next cycle if_valid=0, imem_addr=RESET_PC, halted=fault=0.
